// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned DEF_N_BTN           = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_REPEAT_DELAY    = 12500000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 2500000;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce FSM, optional auto-repeat.
// Auto-repeat counter is built only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic pclk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DELAY) + 1;
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt;
`endif

  btn_state_t       state;
  logic [1:0]       sync_ff;
  logic [CNT_W-1:0] cnt;
  logic             sync;

  assign sync = sync_ff[1];

  always_ff @(posedge pclk) begin
    if (reset) begin
      sync_ff       <= '0;
      state         <= IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt           <= '0;
`endif
    end else begin
      sync_ff       <= {sync_ff[0], raw};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!sync) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state       <= HELD;
            level       <= 1'b1;
            press_pulse <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rpt         <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HELD: begin
          if (!sync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else begin
`ifdef BTN_AUTOREPEAT_EN
            // Pulse on the edge rpt would reach REPEAT_DELAY; reload keeps the period exact.
            if (rpt == RPT_LAST) begin
              press_pulse <= 1'b1;
              rpt         <= RPT_RELOAD;
            end else begin
              rpt <= rpt + 1'b1;
            end
`endif
          end
        end

        RELEASE_WAIT: begin
          if (sync) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Bank of independent button conditioners feeding the pong game logic.
// Define BTN_AUTOREPEAT_EN to build the auto-repeat press pulses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = DEF_N_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("btn_conditioner: invalid timing parameters");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      , .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .pclk          (pclk),
      .reset         (reset),
      .raw           (btn_raw[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
module tb_btn_conditioner;

  localparam int unsigned N  = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic         pclk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int unsigned checks = 0;
  int unsigned errors = 0;

  btn_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_outs(input string sc, input int e,
                            input logic [N-1:0] lv, input logic [N-1:0] pr, input logic [N-1:0] rl);
    check($sformatf("%s@%0d level", sc, e),   32'(btn_level),   32'(lv));
    check($sformatf("%s@%0d press", sc, e),   32'(btn_press),   32'(pr));
    check($sformatf("%s@%0d release", sc, e), 32'(btn_release), 32'(rl));
  endtask

  initial begin
    logic [N-1:0] lv, pr, rl;
    reset   = 1'b1;
    btn_raw = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("reset", i, '0, '0, '0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("idle", i, '0, '0, '0);
    end

    // Clean press on channel 0; edge e is the e-th edge after raw rises.
    btn_raw = 4'b0001;
    for (int e = 0; e <= 22; e++) begin
      tick();
      lv = (e >= 6) ? 4'b0001 : 4'b0000;
      pr = (e == 6 || (AUTOREP && (e == 16 || e == 19 || e == 22))) ? 4'b0001 : 4'b0000;
      check_outs("press", e, lv, pr, '0);
    end

    btn_raw = 4'b0000;
    for (int r = 0; r <= 9; r++) begin
      tick();
      lv = (r < 6) ? 4'b0001 : 4'b0000;
      rl = (r == 6) ? 4'b0001 : 4'b0000;
      check_outs("release", r, lv, '0, rl);
    end

    // Three synchronised cycles high is below the acceptance threshold.
    btn_raw = 4'b0010;
    for (int e = 0; e <= 11; e++) begin
      tick();
      check_outs("glitch", e, '0, '0, '0);
      if (e == 2) btn_raw = 4'b0000;
    end

    // Bounce on channel 2: the repeat after edge 19 lands at 25 instead of 22.
    btn_raw = 4'b0100;
    for (int e = 0; e <= 29; e++) begin
      tick();
      lv = (e >= 6) ? 4'b0100 : 4'b0000;
      pr = (e == 6 || (AUTOREP && (e == 16 || e == 19 || e == 25 || e == 28))) ? 4'b0100 : 4'b0000;
      check_outs("bounce", e, lv, pr, '0);
      if (e == 17) btn_raw = 4'b0000;
      if (e == 19) btn_raw = 4'b0100;
    end

    reset = 1'b1;
    tick();
    check_outs("rst_held", 0, '0, '0, '0);
    reset = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      tick();
      lv = (r >= 7) ? 4'b0100 : 4'b0000;
      pr = (r == 7) ? 4'b0100 : 4'b0000;
      check_outs("rst_held", r, lv, pr, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
